// File: rtl/gcdlcm_seq.sv
// gcdlcm_seq: multi-cycle GCD/LCM sequencer and datapath for the coprocessor.
// GCD uses subtractive Euclid, LCM uses alternating accumulation, one
// compare/step per cycle. Stall holds the core's PC while the block works,
// and Done strobes for one cycle while Result is written back.
// Optional feature: define GCDLCM_WATCHDOG_EN to bound CALC to MAX_ITER steps
// and flag the abort on Err. Otherwise Err is tied low.
module gcdlcm_seq #(
    parameter int WIDTH    = 32,
    parameter int MAX_ITER = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Ovf,
    output logic             Err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_q, b_q, x_q, y_q;
    logic [WIDTH-1:0] a_next, b_next, x_next, y_next;
    logic             op_q, op_next;
    logic [WIDTH-1:0] res_next;
    logic             done_next, ovf_next;
    logic [WIDTH:0]   sum;

`ifdef GCDLCM_WATCHDOG_EN
    localparam int CW = $clog2(MAX_ITER + 1);
    logic [CW-1:0] cnt_q, cnt_next;
    logic          err_q, err_next;
    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

    // The PC is held while a launch is requested and throughout CALC, never during reset.
    assign Stall = ~reset & (((state == S_IDLE) & Start) | (state == S_CALC));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, regardless of statement order.
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state and datapath step: capture in IDLE, one compare/step in CALC.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        a_next     = a_q;
        b_next     = b_q;
        x_next     = x_q;
        y_next     = y_q;
        op_next    = op_q;
        res_next   = Result;
        done_next  = 1'b0;
        ovf_next   = 1'b0;
        sum        = '0;
`ifdef GCDLCM_WATCHDOG_EN
        cnt_next   = cnt_q;
        err_next   = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (Start) begin
                    a_next  = SrcA;
                    b_next  = SrcB;
                    x_next  = SrcA;
                    y_next  = SrcB;
                    op_next = Op;
`ifdef GCDLCM_WATCHDOG_EN
                    cnt_next = '0;
`endif
                    if (SrcA == '0 || SrcB == '0) begin
                        // With one operand zero, the OR is the other operand, which is the GCD.
                        state_next = S_DONE;
                        done_next  = 1'b1;
                        res_next   = Op ? '0 : (SrcA | SrcB);
                    end else begin
                        state_next = S_CALC;
                    end
                end
            end
            S_CALC: begin
`ifdef GCDLCM_WATCHDOG_EN
                if (cnt_q == CW'(MAX_ITER)) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                    res_next   = '0;
                    err_next   = 1'b1;
                end else
`endif
                if (x_q == y_q) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                    res_next   = x_q;
                end else if (!op_q) begin
                    if (x_q > y_q) x_next = x_q - y_q;
                    else           y_next = y_q - x_q;
`ifdef GCDLCM_WATCHDOG_EN
                    cnt_next = cnt_q + CW'(1);
`endif
                end else begin
                    // Advance the smaller multiple. The extra bit catches wrap-around.
                    if (x_q < y_q) sum = {1'b0, x_q} + {1'b0, a_q};
                    else           sum = {1'b0, y_q} + {1'b0, b_q};
                    if (sum[WIDTH]) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                        res_next   = '0;
                        ovf_next   = 1'b1;
                    end else begin
                        if (x_q < y_q) x_next = sum[WIDTH-1:0];
                        else           y_next = sum[WIDTH-1:0];
`ifdef GCDLCM_WATCHDOG_EN
                        cnt_next = cnt_q + CW'(1);
`endif
                    end
                end
            end
            S_DONE: begin
                // Start is still high from the same instruction here. Leaving
                // unconditionally stops it from relaunching.
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            op_q   <= 1'b0;
            Result <= '0;
            Done   <= 1'b0;
            Ovf    <= 1'b0;
`ifdef GCDLCM_WATCHDOG_EN
            cnt_q  <= '0;
            err_q  <= 1'b0;
`endif
        end else begin
            a_q    <= a_next;
            b_q    <= b_next;
            x_q    <= x_next;
            y_q    <= y_next;
            op_q   <= op_next;
            Result <= res_next;
            Done   <= done_next;
            Ovf    <= ovf_next;
`ifdef GCDLCM_WATCHDOG_EN
            cnt_q  <= cnt_next;
            err_q  <= err_next;
`endif
        end
    end

endmodule

// File: tb/tb_gcdlcm_seq.sv
// tb_gcdlcm_seq: directed test of gcdlcm_seq with hand-computed expectations.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the falling edge.
module tb_gcdlcm_seq;

    localparam int W = 32;
`ifdef GCDLCM_WATCHDOG_EN
    localparam int MAX_ITER_TB = 16;
`else
    localparam int MAX_ITER_TB = 1024;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         Start;
    logic         Op;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         Stall;
    logic         Done;
    logic [W-1:0] Result;
    logic         Ovf;
    logic         Err;

    int checks = 0;
    int errors = 0;

    gcdlcm_seq #(.WIDTH(W), .MAX_ITER(MAX_ITER_TB)) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .Op     (Op),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .Stall  (Stall),
        .Done   (Done),
        .Result (Result),
        .Ovf    (Ovf),
        .Err    (Err)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one operation, counts stalled cycles until Done, then checks the
    // write-back values and that Done lasts exactly one cycle.
    task automatic run_op(input string tag, input logic op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input logic exp_ovf, input logic exp_err, input int exp_stalls,
                          input bit drop_start);
        int stalls;
        bit got;
        stalls = 0;
        got    = 1'b0;
        Start  = 1'b1;
        Op     = op;
        SrcA   = a;
        SrcB   = b;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (Done) begin
                got = 1'b1;
                break;
            end
            if (!Stall) break;
            stalls++;
            tick();
            if (drop_start) Start = 1'b0;
        end
        check({tag, " done seen"}, W'(got), W'(1));
        check({tag, " stall cycles"}, W'(stalls), W'(exp_stalls));
        check({tag, " result"}, Result, exp_res);
        check({tag, " ovf"}, W'(Ovf), W'(exp_ovf));
        check({tag, " err"}, W'(Err), W'(exp_err));
        check({tag, " stall in done"}, W'(Stall), W'(0));
        tick();
        Start = 1'b0;
        @(negedge clk);
        check({tag, " done one cycle"}, W'(Done), W'(0));
        check({tag, " result held"}, Result, exp_res);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        Op    = 1'b0;
        SrcA  = '0;
        SrcB  = '0;
        tick();
        tick();

        // Reset values, and Stall suppressed by reset even with Start high.
        @(negedge clk);
        check("rst done", W'(Done), W'(0));
        check("rst ovf", W'(Ovf), W'(0));
        check("rst err", W'(Err), W'(0));
        check("rst result", Result, W'(0));
        Start = 1'b1;
        #1;
        check("rst stall with start", W'(Stall), W'(0));
        Start = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("idle stall", W'(Stall), W'(0));
        tick();

        // op, a, b, result, ovf, err, stalled cycles, drop Start after launch
        run_op("gcd 12,18", 1'b0, 32'd12, 32'd18, 32'd6, 1'b0, 1'b0, 4, 1'b0);
        run_op("lcm 4,6", 1'b1, 32'd4, 32'd6, 32'd12, 1'b0, 1'b0, 5, 1'b0);
        run_op("gcd 0,9", 1'b0, 32'd0, 32'd9, 32'd9, 1'b0, 1'b0, 1, 1'b0);
        run_op("lcm 7,0", 1'b1, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1, 1'b0);
        run_op("gcd 0,0", 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1, 1'b0);
        run_op("gcd 5,5", 1'b0, 32'd5, 32'd5, 32'd5, 1'b0, 1'b0, 2, 1'b0);
        run_op("lcm ovf", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0, 1'b1, 1'b0, 2, 1'b0);
        run_op("lcm 3,5", 1'b1, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 8, 1'b0);
        run_op("gcd 18,12 start drop", 1'b0, 32'd18, 32'd12, 32'd6, 1'b0, 1'b0, 4, 1'b1);
`ifdef GCDLCM_WATCHDOG_EN
        run_op("gcd 1,1000 watchdog", 1'b0, 32'd1, 32'd1000, 32'd0, 1'b0, 1'b1, 18, 1'b0);
`else
        run_op("gcd 1,1000", 1'b0, 32'd1, 32'd1000, 32'd1, 1'b0, 1'b0, 1001, 1'b0);
`endif

        // Reset on the 3rd CALC cycle of GCD(100,1) discards the operation.
        Start = 1'b1;
        Op    = 1'b0;
        SrcA  = 32'd100;
        SrcB  = 32'd1;
        @(negedge clk);
        check("abort launch stall", W'(Stall), W'(1));
        tick();
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("abort stall in reset", W'(Stall), W'(0));
        tick();
        SrcA = 32'd8;
        SrcB = 32'd12;
        @(negedge clk);
        check("abort no done", W'(Done), W'(0));
        check("abort stall", W'(Stall), W'(0));
        check("abort result cleared", Result, W'(0));
        tick();
        reset = 1'b0;
        run_op("gcd 8,12 after reset", 1'b0, 32'd8, 32'd12, 32'd4, 1'b0, 1'b0, 4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
